// File: rtl/mips_run_control.sv
// Run-control sequencer for the pipelined Mips core.
// Holds the core in a stretched reset, gates its clock-enable, and obeys
// RUN / HALT / STEP / RESTART commands. Also owns a small PC breakpoint table
// and a free-running count of enabled cycles.
//
// Command handshake: a command transfers on a posedge where
// cmd_valid && cmd_ready are both high. cmd_ready depends only on the
// registered state (low while the core is held in reset). cmd_op/cmd_count
// are sampled only on that transfer edge; the offerer may change them freely
// when no transfer happens. There is no back-pressure beyond the RESET state.
module mips_run_control #(
  parameter int RESET_CYCLES = 4,
  parameter int START_RUN    = 1,
  parameter int ADDR_WIDTH   = 32,
  parameter int COUNT_WIDTH  = 32,
  parameter int NBREAK       = 4,
  localparam int IW          = (NBREAK > 1) ? $clog2(NBREAK) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic                   bp_we,
  input  logic [IW-1:0]          bp_index,
  input  logic [ADDR_WIDTH-1:0]  bp_addr,
  input  logic                   bp_en,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   pc_valid,
  output logic                   core_reset,
  output logic                   core_enable,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic                   bp_hit,
  output logic [IW-1:0]          bp_hit_index
);

  // Timer must hold RESET_CYCLES itself.
  localparam int TW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_HALTED   = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_STEPPING = 2'd3
  } state_t;

  localparam logic [1:0] OP_RUN     = 2'd0;
  localparam logic [1:0] OP_HALT    = 2'd1;
  localparam logic [1:0] OP_STEP    = 2'd2;
  localparam logic [1:0] OP_RESTART = 2'd3;

  state_t                 st_q;
  logic [TW-1:0]          timer_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [COUNT_WIDTH-1:0] cycle_q;
  logic [ADDR_WIDTH-1:0]  bp_addr_q [NBREAK];
  logic                   bp_en_q   [NBREAK];
  logic                   hit_q;
  logic [IW-1:0]          hit_idx_q;

  logic                   enabled;
  logic                   cmd_fire;
  logic                   match_any;
  logic [IW-1:0]          match_idx;
  logic                   bp_match;

  // Every output is a decode of registered state; only cmd_ready feeds back
  // into the command handshake.
  assign state        = st_q;
  assign core_reset   = (st_q == ST_RESET);
  assign enabled      = (st_q == ST_RUNNING) || (st_q == ST_STEPPING);
  assign core_enable  = enabled;
  assign cmd_ready    = (st_q != ST_RESET);
  assign cycle_count  = cycle_q;
  assign bp_hit       = hit_q;
  assign bp_hit_index = hit_idx_q;
  assign cmd_fire     = cmd_valid && cmd_ready;
  assign bp_match     = enabled && pc_valid && match_any;

  // Breakpoint compare against current table contents; scanning downward
  // leaves the lowest matching index in match_idx.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NBREAK - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_addr_q[i] == pc)) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end
    end
  end

  // Run-control sequencer, cycle counter and breakpoint table.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q        <= ST_RESET;
      timer_q     <= TW'(RESET_CYCLES);
      remaining_q <= '0;
      cycle_q     <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      for (int i = 0; i < NBREAK; i++) begin
        bp_addr_q[i] <= '0;
        bp_en_q[i]   <= 1'b0;
      end
    end else begin
      if (enabled) begin
        cycle_q <= cycle_q + COUNT_WIDTH'(1);
      end

      // Table writes land next cycle; indices past the table match no entry.
      for (int i = 0; i < NBREAK; i++) begin
        if (bp_we && (bp_index == IW'(i))) begin
          bp_addr_q[i] <= bp_addr;
          bp_en_q[i]   <= bp_en;
        end
      end

      case (st_q)
        ST_RESET: begin
          timer_q <= timer_q - TW'(1);
          if (timer_q == TW'(1)) begin
            st_q <= (START_RUN != 0) ? ST_RUNNING : ST_HALTED;
          end
        end
        default: begin
          if (cmd_fire && (cmd_op == OP_RESTART)) begin
            st_q    <= ST_RESET;
            timer_q <= TW'(RESET_CYCLES);
            hit_q   <= 1'b0;
          end else if (bp_match) begin
            // Any RUN/HALT/STEP offered in this cycle is consumed and dropped.
            st_q      <= ST_HALTED;
            hit_q     <= 1'b1;
            hit_idx_q <= match_idx;
          end else if (cmd_fire) begin
            case (cmd_op)
              OP_RUN: begin
                st_q  <= ST_RUNNING;
                hit_q <= 1'b0;
              end
              OP_HALT: begin
                st_q <= ST_HALTED;
              end
              OP_STEP: begin
                hit_q <= 1'b0;
                if (cmd_count != '0) begin
                  st_q        <= ST_STEPPING;
                  remaining_q <= cmd_count;
                end else begin
                  st_q <= ST_HALTED;
                end
              end
              default: begin
                st_q <= st_q;
              end
            endcase
          end else if (st_q == ST_STEPPING) begin
            remaining_q <= remaining_q - COUNT_WIDTH'(1);
            if (remaining_q == COUNT_WIDTH'(1)) begin
              st_q <= ST_HALTED;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_control.sv
// Directed bench for mips_run_control (RESET_CYCLES=4, COUNT_WIDTH=4, NBREAK=3).
// A second instance with START_RUN=0 shares the inputs and is only checked
// for where it lands after the reset stretch.
module tb_mips_run_control;

  localparam int CW = 4;
  localparam int AW = 32;
  localparam int NB = 3;
  localparam int IW = 2;

  localparam logic [1:0] S_RST = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_RUN = 2'd2;
  localparam logic [1:0] S_STP = 2'd3;

  localparam logic [1:0] OP_RUN     = 2'd0;
  localparam logic [1:0] OP_HALT    = 2'd1;
  localparam logic [1:0] OP_STEP    = 2'd2;
  localparam logic [1:0] OP_RESTART = 2'd3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          bp_we;
  logic [IW-1:0] bp_index;
  logic [AW-1:0] bp_addr;
  logic          bp_en;
  logic [AW-1:0] pc;
  logic          pc_valid;

  logic          cmd_ready, core_reset, core_enable, bp_hit;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;
  logic [IW-1:0] bp_hit_index;

  logic          h_cmd_ready, h_core_reset, h_core_enable, h_bp_hit;
  logic [1:0]    h_state;
  logic [CW-1:0] h_cycle_count;
  logic [IW-1:0] h_bp_hit_index;

  mips_run_control #(
    .RESET_CYCLES(4), .START_RUN(1), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .NBREAK(NB)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .bp_we(bp_we), .bp_index(bp_index), .bp_addr(bp_addr), .bp_en(bp_en),
    .pc(pc), .pc_valid(pc_valid),
    .core_reset(core_reset), .core_enable(core_enable), .state(state),
    .cycle_count(cycle_count), .bp_hit(bp_hit), .bp_hit_index(bp_hit_index)
  );

  mips_run_control #(
    .RESET_CYCLES(4), .START_RUN(0), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .NBREAK(NB)
  ) dut_halt (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(h_cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .bp_we(bp_we), .bp_index(bp_index), .bp_addr(bp_addr), .bp_en(bp_en),
    .pc(pc), .pc_valid(pc_valid),
    .core_reset(h_core_reset), .core_enable(h_core_enable), .state(h_state),
    .cycle_count(h_cycle_count), .bp_hit(h_bp_hit), .bp_hit_index(h_bp_hit_index)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  string       tag_q[$];

  // Observed vector: {state, core_reset, core_enable, cmd_ready, bp_hit, bp_hit_index, cycle_count}
  function automatic logic [11:0] observed();
    return {state, core_reset, core_enable, cmd_ready, bp_hit, bp_hit_index, cycle_count};
  endfunction

  function automatic logic [11:0] expect_vec(logic [1:0] st, logic [CW-1:0] cc,
                                             logic hit, logic [IW-1:0] idx);
    logic rst_o, en_o, rdy_o;
    rst_o = (st == S_RST);
    en_o  = (st == S_RUN) || (st == S_STP);
    rdy_o = (st != S_RST);
    return {st, rst_o, en_o, rdy_o, hit, idx, cc};
  endfunction

  task automatic push_exp(input string tag, input logic [1:0] st, input logic [CW-1:0] cc,
                          input logic hit, input logic [IW-1:0] idx);
    exp_q.push_back(expect_vec(st, cc, hit, idx));
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [11:0] e;
    logic [11:0] o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic check_val(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expect outputs after the next edge, advance, compare.
  task automatic step(input string tag, input logic [1:0] st, input logic [CW-1:0] cc,
                      input logic hit, input logic [IW-1:0] idx);
    push_exp(tag, st, cc, hit, idx);
    tick();
    pop_check();
  endtask

  task automatic check_now(input string tag, input logic [1:0] st, input logic [CW-1:0] cc,
                           input logic hit, input logic [IW-1:0] idx);
    push_exp(tag, st, cc, hit, idx);
    pop_check();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [CW-1:0] n);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = n;
  endtask

  task automatic no_cmd();
    cmd_valid = 1'b0;
    cmd_op    = OP_RUN;
    cmd_count = '0;
  endtask

  task automatic bp_write(input logic [IW-1:0] idx, input logic [AW-1:0] addr, input logic en);
    bp_we    = 1'b1;
    bp_index = idx;
    bp_addr  = addr;
    bp_en    = en;
  endtask

  task automatic set_pc(input logic [AW-1:0] a, input logic v);
    pc       = a;
    pc_valid = v;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_en;
    reset = 1'b1;
    no_cmd();
    bp_we = 1'b0; bp_index = '0; bp_addr = '0; bp_en = 1'b0;
    set_pc('0, 1'b0);

    // Reset held three cycles, then a 4-cycle stretch before RUNNING.
    tick(); tick(); tick();
    check_now("reset_state", S_RST, 0, 1'b0, 0);
    reset = 1'b0;
    step("rst_len1", S_RST, 0, 1'b0, 0);
    step("rst_len2", S_RST, 0, 1'b0, 0);
    step("rst_len3", S_RST, 0, 1'b0, 0);
    step("start_run", S_RUN, 0, 1'b0, 0);
    check_val("start_halted_variant", int'(h_state), int'(S_HLT));
    step("count1", S_RUN, 1, 1'b0, 0);
    step("count2", S_RUN, 2, 1'b0, 0);
    step("count3", S_RUN, 3, 1'b0, 0);

    // HALT counts the cycle it is accepted in.
    send_cmd(OP_HALT, 0);
    step("halt", S_HLT, 4, 1'b0, 0);
    no_cmd();
    step("halt_hold", S_HLT, 4, 1'b0, 0);

    // STEP 5: exactly five enabled cycles.
    send_cmd(OP_STEP, 5);
    step("step5_go", S_STP, 4, 1'b0, 0);
    no_cmd();
    n_en = 0;
    for (int i = 0; i < 20 && state != S_HLT; i++) begin
      if (core_enable) n_en++;
      tick();
    end
    check_val("step5_enabled", n_en, 5);
    check_now("step5_end", S_HLT, 9, 1'b0, 0);

    // STEP 0 stays halted.
    send_cmd(OP_STEP, 0);
    step("step0", S_HLT, 9, 1'b0, 0);
    no_cmd();
    step("step0_hold", S_HLT, 9, 1'b0, 0);

    // Breakpoint table: entries 2 and 1 at 0x40; index 3 is past the table.
    bp_write(2, 32'h40, 1'b1);
    step("bpw2", S_HLT, 9, 1'b0, 0);
    bp_write(1, 32'h40, 1'b1);
    step("bpw1", S_HLT, 9, 1'b0, 0);
    bp_write(3, 32'h80, 1'b1);
    step("bpw3_ignored", S_HLT, 9, 1'b0, 0);
    bp_we = 1'b0;

    send_cmd(OP_RUN, 0);
    step("bp_run", S_RUN, 9, 1'b0, 0);
    no_cmd();
    set_pc(32'h40, 1'b1);
    step("bp_hit_lowest", S_HLT, 10, 1'b1, 1);
    set_pc(32'h40, 1'b0);
    step("bp_sticky", S_HLT, 10, 1'b1, 1);
    send_cmd(OP_RUN, 0);
    step("run_clears_hit", S_RUN, 10, 1'b0, 1);
    no_cmd();

    // Same-cycle write uses old contents; hit follows on the next cycle.
    set_pc(32'h80, 1'b1);
    bp_write(0, 32'h80, 1'b1);
    step("bp_old_contents", S_RUN, 11, 1'b0, 1);
    bp_we = 1'b0;
    step("bp_new_entry", S_HLT, 12, 1'b1, 0);
    set_pc(32'h80, 1'b0);
    bp_write(0, 32'h0, 1'b0);
    step("bp_clear0", S_HLT, 12, 1'b1, 0);
    bp_we = 1'b0;

    // STEP 10 cut short by a breakpoint on the third enabled cycle; RUN dropped.
    send_cmd(OP_STEP, 10);
    step("step10_go", S_STP, 12, 1'b0, 0);
    no_cmd();
    step("step10_c1", S_STP, 13, 1'b0, 0);
    step("step10_c2", S_STP, 14, 1'b0, 0);
    set_pc(32'h40, 1'b1);
    send_cmd(OP_RUN, 0);
    step("step10_bp", S_HLT, 15, 1'b1, 1);
    no_cmd();
    set_pc(32'h40, 1'b0);
    step("run_dropped", S_HLT, 15, 1'b1, 1);

    // RESTART beats a breakpoint; counter wraps 15 -> 0 in that cycle.
    send_cmd(OP_RUN, 0);
    step("rerun", S_RUN, 15, 1'b0, 1);
    set_pc(32'h40, 1'b1);
    send_cmd(OP_RESTART, 0);
    step("restart_wins", S_RST, 0, 1'b0, 1);
    set_pc(32'h40, 1'b0);
    send_cmd(OP_HALT, 0);
    step("restart_r1", S_RST, 0, 1'b0, 1);
    step("restart_r2", S_RST, 0, 1'b0, 1);
    step("restart_r3", S_RST, 0, 1'b0, 1);
    no_cmd();
    step("restart_out", S_RUN, 0, 1'b0, 1);
    set_pc(32'h40, 1'b1);
    step("bp_kept", S_HLT, 1, 1'b1, 1);
    set_pc(32'h40, 1'b0);

    // Wrap while running.
    send_cmd(OP_RUN, 0);
    step("wrap_run", S_RUN, 1, 1'b0, 1);
    no_cmd();
    for (int i = 0; i < 14; i++) tick();
    check_now("wrap_max", S_RUN, 15, 1'b0, 1);
    step("wrap_zero", S_RUN, 0, 1'b0, 1);

    // Reset in the middle of a STEP clears everything.
    send_cmd(OP_STEP, 5);
    step("step_mid", S_STP, 1, 1'b0, 1);
    no_cmd();
    step("step_mid2", S_STP, 2, 1'b0, 1);
    reset = 1'b1;
    step("reset_mid", S_RST, 0, 1'b0, 0);
    reset = 1'b0;
    step("rst2_len1", S_RST, 0, 1'b0, 0);
    step("rst2_len2", S_RST, 0, 1'b0, 0);
    step("rst2_len3", S_RST, 0, 1'b0, 0);
    step("rst2_out", S_RUN, 0, 1'b0, 0);
    set_pc(32'h40, 1'b1);
    step("bp_cleared", S_RUN, 1, 1'b0, 0);
    set_pc(32'h40, 1'b0);

    check_val("queue_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
